am2950_fifo_port: RTL and testbench

//  Registered, buffered bidirectional bus port: successor to the 8-bit inverting

---
 rtl/am2950_fifo_port_if.sv | 53 +++++
 rtl/am2950_fifo_port.sv | 129 ++++++++++++
 tb/tb_am2950_fifo_port.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/am2950_fifo_port_if.sv
`default_nettype none
// ============================================================================
// Module   : am2950_fifo_port_if
// Brief    : Control and status bundle for the am2950_fifo_port dual FIFO.
//            The bidirectional buses a/b stay plain module ports because
//            they are resolved tristate nets.
// Revision : 1.0  initial release
// ============================================================================
interface am2950_fifo_port_if #(
    parameter int DEPTH = 4
);
    localparam int C_CW = $clog2(DEPTH + 1);

    // A->B direction controls
    logic            wr_ab;
    logic            rd_ab;
    logic            oe_b_;
    logic            clr_ab;
    // B->A direction controls
    logic            wr_ba;
    logic            rd_ba;
    logic            oe_a_;
    logic            clr_ba;
    // A->B status
    logic            empty_ab;
    logic            full_ab;
    logic            ovf_ab;
    logic            unf_ab;
    logic [C_CW-1:0] cnt_ab;
    // B->A status
    logic            empty_ba;
    logic            full_ba;
    logic            ovf_ba;
    logic            unf_ba;
    logic [C_CW-1:0] cnt_ba;

    // Bus-master side: issues commands, observes status
    modport master (
        output wr_ab, rd_ab, oe_b_, clr_ab,
        output wr_ba, rd_ba, oe_a_, clr_ba,
        input  empty_ab, full_ab, ovf_ab, unf_ab, cnt_ab,
        input  empty_ba, full_ba, ovf_ba, unf_ba, cnt_ba
    );

    // FIFO port side: accepts commands, reports status
    modport slave (
        input  wr_ab, rd_ab, oe_b_, clr_ab,
        input  wr_ba, rd_ba, oe_a_, clr_ba,
        output empty_ab, full_ab, ovf_ab, unf_ab, cnt_ab,
        output empty_ba, full_ba, ovf_ba, unf_ba, cnt_ba
    );
endinterface
`default_nettype wire

// File: rtl/am2950_fifo_port.sv
`default_nettype none
// ============================================================================
// Module   : am2950_fifo_port
// Brief    : Registered bidirectional bus port with two independent FIFOs
//            (A->B and B->A), optional inversion on the driven side,
//            active-low output enables and sticky overflow/underflow flags.
// Revision : 1.0  initial release
// ============================================================================
module am2950_fifo_port #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter bit INVERT = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    inout  wire logic [WIDTH-1:0] a,
    inout  wire logic [WIDTH-1:0] b,
    am2950_fifo_port_if.slave     bus
);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_PW = $clog2(DEPTH);

    // Index 0 is the A->B direction, index 1 is B->A
    logic [1:0]            w_wr;
    logic [1:0]            w_rd;
    logic [1:0]            w_clr;
    logic [1:0][WIDTH-1:0] w_din;
    logic [1:0][WIDTH-1:0] w_out;
    logic [1:0][c_CW-1:0]  w_cnt;
    logic [1:0]            w_ovf;
    logic [1:0]            w_unf;

    assign w_wr  = {bus.wr_ba,  bus.wr_ab};
    assign w_rd  = {bus.rd_ba,  bus.rd_ab};
    assign w_clr = {bus.clr_ba, bus.clr_ab};
    // Samples are taken raw from the source bus; inversion only on drive
    assign w_din = {b, a};

    for (genvar d = 0; d < 2; d++) begin : g_dir
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [c_PW-1:0]  r_wp;
        logic [c_PW-1:0]  r_rp;
        logic [c_CW-1:0]  r_cnt;
        logic [WIDTH-1:0] r_out;
        logic             r_ovf;
        logic             r_unf;
        logic             w_empty;
        logic             w_full;
        logic             w_pop;
        logic             w_push;
        logic [c_PW-1:0]  w_rp_nxt;
        logic [c_CW-1:0]  w_cnt_nxt;

        assign w_empty   = (r_cnt == '0);
        assign w_full    = (r_cnt == c_CW'(DEPTH));
        assign w_pop     = w_rd[d] & ~w_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        assign w_push    = w_wr[d] & (~w_full | w_pop);
        assign w_rp_nxt  = w_pop ? r_rp + c_PW'(1) : r_rp;
        assign w_cnt_nxt = r_cnt + c_CW'(w_push) - c_CW'(w_pop);

        // Storage array; no reset needed since reads are gated by r_cnt
        always_ff @(posedge clk) begin
            if (!rst && !w_clr[d] && w_push) begin
                r_mem[r_wp] <= w_din[d];
            end
        end

        // Pointers, occupancy, sticky flags and fall-through output word
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
                r_out <= '0;
            end else if (w_clr[d]) begin
                // Flush keeps the output word so the bus does not glitch
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wp <= r_wp + c_PW'(1);
                end
                r_rp  <= w_rp_nxt;
                r_cnt <= w_cnt_nxt;
                if (w_wr[d] && w_full && !w_rd[d]) begin
                    r_ovf <= 1'b1;
                end
                if (w_rd[d] && w_empty) begin
                    r_unf <= 1'b1;
                end
                // New head comes from the bypass when it is the word being
                // written this edge, otherwise from storage; empty keeps last
                if (w_cnt_nxt != '0) begin
                    r_out <= (w_push && (r_wp == w_rp_nxt)) ? w_din[d]
                                                            : r_mem[w_rp_nxt];
                end
            end
        end

        assign w_out[d] = r_out;
        assign w_cnt[d] = r_cnt;
        assign w_ovf[d] = r_ovf;
        assign w_unf[d] = r_unf;
    end : g_dir

    // Tristate drive is purely combinational from the active-low enables
    assign b = bus.oe_b_ ? {WIDTH{1'bz}} : (INVERT ? ~w_out[0] : w_out[0]);
    assign a = bus.oe_a_ ? {WIDTH{1'bz}} : (INVERT ? ~w_out[1] : w_out[1]);

    assign bus.cnt_ab   = w_cnt[0];
    assign bus.empty_ab = (w_cnt[0] == '0);
    assign bus.full_ab  = (w_cnt[0] == c_CW'(DEPTH));
    assign bus.ovf_ab   = w_ovf[0];
    assign bus.unf_ab   = w_unf[0];

    assign bus.cnt_ba   = w_cnt[1];
    assign bus.empty_ba = (w_cnt[1] == '0);
    assign bus.full_ba  = (w_cnt[1] == c_CW'(DEPTH));
    assign bus.ovf_ba   = w_ovf[1];
    assign bus.unf_ba   = w_unf[1];

endmodule
`default_nettype wire

// File: tb/tb_am2950_fifo_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_am2950_fifo_port
// Brief    : Scoreboard bench for am2950_fifo_port (WIDTH=8, DEPTH=4,
//            INVERT=1). Queues hold the expected driven words per direction.
// Revision : 1.0  initial release
// ============================================================================
module tb_am2950_fifo_port;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam bit INVERT = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wire  [WIDTH-1:0] a;
    wire  [WIDTH-1:0] b;
    logic [WIDTH-1:0] a_drv = '0;
    logic [WIDTH-1:0] b_drv = '0;
    logic             a_en  = 1'b0;
    logic             b_en  = 1'b0;

    assign a = a_en ? a_drv : {WIDTH{1'bz}};
    assign b = b_en ? b_drv : {WIDTH{1'bz}};

    am2950_fifo_port_if #(.DEPTH(DEPTH)) bus ();

    am2950_fifo_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .INVERT (INVERT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: expected driven words, head at index 0
    logic [WIDTH-1:0] q_ab [$];
    logic [WIDTH-1:0] q_ba [$];
    logic [WIDTH-1:0] last_ab;
    logic [WIDTH-1:0] last_ba;
    logic             exp_ovf_ab, exp_unf_ab, exp_ovf_ba, exp_unf_ba;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [WIDTH-1:0] drv(input logic [WIDTH-1:0] v);
        return INVERT ? ~v : v;
    endfunction

    function automatic logic [WIDTH-1:0] exp_b();
        return (q_ab.size() > 0) ? q_ab[0] : last_ab;
    endfunction

    function automatic logic [WIDTH-1:0] exp_a();
        return (q_ba.size() > 0) ? q_ba[0] : last_ba;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q_ab.delete();
        q_ba.delete();
        last_ab    = drv('0);
        last_ba    = drv('0);
        exp_ovf_ab = 1'b0;
        exp_unf_ab = 1'b0;
        exp_ovf_ba = 1'b0;
        exp_unf_ba = 1'b0;
    endtask

    task automatic chk_ab(input string tag);
        check({tag, "_cnt_ab"},   32'(bus.cnt_ab),   q_ab.size());
        check({tag, "_empty_ab"}, 32'(bus.empty_ab), 32'(q_ab.size() == 0));
        check({tag, "_full_ab"},  32'(bus.full_ab),  32'(q_ab.size() == DEPTH));
        check({tag, "_ovf_ab"},   32'(bus.ovf_ab),   32'(exp_ovf_ab));
        check({tag, "_unf_ab"},   32'(bus.unf_ab),   32'(exp_unf_ab));
        if (!bus.oe_b_) check({tag, "_b"}, 32'(b), 32'(exp_b()));
    endtask

    task automatic chk_ba(input string tag);
        check({tag, "_cnt_ba"},   32'(bus.cnt_ba),   q_ba.size());
        check({tag, "_empty_ba"}, 32'(bus.empty_ba), 32'(q_ba.size() == 0));
        check({tag, "_full_ba"},  32'(bus.full_ba),  32'(q_ba.size() == DEPTH));
        check({tag, "_ovf_ba"},   32'(bus.ovf_ba),   32'(exp_ovf_ba));
        check({tag, "_unf_ba"},   32'(bus.unf_ba),   32'(exp_unf_ba));
        if (!bus.oe_a_) check({tag, "_a"}, 32'(a), 32'(exp_a()));
    endtask

    task automatic push_ab(input logic [WIDTH-1:0] v);
        a_en = 1'b1; a_drv = v; bus.wr_ab = 1'b1;
        if (q_ab.size() == DEPTH) exp_ovf_ab = 1'b1;
        else q_ab.push_back(drv(v));
        tick();
        bus.wr_ab = 1'b0; a_en = 1'b0;
    endtask

    task automatic pop_ab();
        if (q_ab.size() == 0) begin
            exp_unf_ab = 1'b1;
        end else begin
            if (!bus.oe_b_) check("head_b", 32'(b), 32'(q_ab[0]));
            last_ab = q_ab.pop_front();
        end
        bus.rd_ab = 1'b1;
        tick();
        bus.rd_ab = 1'b0;
    endtask

    task automatic push_pop_ab(input logic [WIDTH-1:0] v);
        a_en = 1'b1; a_drv = v; bus.wr_ab = 1'b1; bus.rd_ab = 1'b1;
        if (q_ab.size() == 0) begin
            exp_unf_ab = 1'b1;
        end else begin
            if (!bus.oe_b_) check("head_b_wr_rd", 32'(b), 32'(q_ab[0]));
            last_ab = q_ab.pop_front();
        end
        q_ab.push_back(drv(v));
        tick();
        bus.wr_ab = 1'b0; bus.rd_ab = 1'b0; a_en = 1'b0;
    endtask

    task automatic clr_ab();
        if (q_ab.size() > 0) last_ab = q_ab[0];
        q_ab.delete();
        exp_ovf_ab = 1'b0; exp_unf_ab = 1'b0;
        bus.clr_ab = 1'b1;
        tick();
        bus.clr_ab = 1'b0;
    endtask

    // from_tb=0 samples whatever the DUT is driving on b (loopback)
    task automatic push_ba(input logic [WIDTH-1:0] v, input bit from_tb);
        if (from_tb) begin b_en = 1'b1; b_drv = v; end
        bus.wr_ba = 1'b1;
        if (q_ba.size() == DEPTH) exp_ovf_ba = 1'b1;
        else q_ba.push_back(drv(v));
        tick();
        bus.wr_ba = 1'b0; b_en = 1'b0;
    endtask

    task automatic pop_ba();
        if (q_ba.size() == 0) begin
            exp_unf_ba = 1'b1;
        end else begin
            if (!bus.oe_a_) check("head_a", 32'(a), 32'(q_ba[0]));
            last_ba = q_ba.pop_front();
        end
        bus.rd_ba = 1'b1;
        tick();
        bus.rd_ba = 1'b0;
    endtask

    task automatic clr_ba();
        if (q_ba.size() > 0) last_ba = q_ba[0];
        q_ba.delete();
        exp_ovf_ba = 1'b0; exp_unf_ba = 1'b0;
        bus.clr_ba = 1'b1;
        tick();
        bus.clr_ba = 1'b0;
    endtask

    // Directed sequence with scoreboard checking
    initial begin
        bus.wr_ab = 1'b0; bus.rd_ab = 1'b0; bus.clr_ab = 1'b0; bus.oe_b_ = 1'b0;
        bus.wr_ba = 1'b0; bus.rd_ba = 1'b0; bus.clr_ba = 1'b0; bus.oe_a_ = 1'b1;
        model_reset();

        // T1: reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_ab("t1");
        chk_ba("t1");

        // T2: single word, fall-through then hold after pop
        push_ab(8'h3C);
        chk_ab("t2_push");
        pop_ab();
        chk_ab("t2_pop");

        // T3: fill, overflow, drain, clear
        for (int i = 1; i <= DEPTH; i++) push_ab(8'(i));
        chk_ab("t3_full");
        push_ab(8'h05);
        chk_ab("t3_ovf");
        for (int i = 0; i < DEPTH; i++) pop_ab();
        chk_ab("t3_drain");
        clr_ab();
        chk_ab("t3_clr");

        // T4: simultaneous write+read on a full FIFO
        for (int i = 1; i <= DEPTH; i++) push_ab(8'(i));
        push_pop_ab(8'hAA);
        chk_ab("t4_wrrd");
        for (int i = 0; i < DEPTH; i++) pop_ab();
        chk_ab("t4_drain");
        // write+read on empty: push only, underflow flagged
        push_pop_ab(8'h77);
        chk_ab("t4_empty_wrrd");

        // T5: B->A underflow and clear, A->B untouched
        pop_ba();
        chk_ba("t5_unf");
        chk_ab("t5_ab_same1");
        clr_ba();
        chk_ba("t5_clr");
        push_ab(8'h5A);
        push_ba(exp_b(), 1'b0);   // loopback of DUT-driven b
        bus.oe_b_ = 1'b1;
        push_ba(8'h11, 1'b1);
        bus.oe_a_ = 1'b0;
        #1;
        chk_ba("t5_ba_fill");
        pop_ba();
        pop_ba();
        chk_ba("t5_ba_drain");
        bus.oe_b_ = 1'b0;
        #1;
        chk_ab("t5_ab_same2");

        // T6: reset with 3 words in each FIFO, then tristate release
        bus.oe_a_ = 1'b1;
        #1;
        push_ab(8'h21);
        chk_ab("t6_ab3");
        bus.oe_b_ = 1'b1;
        push_ba(8'h31, 1'b1);
        push_ba(8'h32, 1'b1);
        push_ba(8'h33, 1'b1);
        chk_ba("t6_ba3");
        rst = 1'b1;
        bus.wr_ab = 1'b1; bus.wr_ba = 1'b1;   // rst must win over writes
        tick();
        rst = 1'b0;
        bus.wr_ab = 1'b0; bus.wr_ba = 1'b0;
        model_reset();
        chk_ab("t6_rst");
        chk_ba("t6_rst");
        a_en = 1'b1; a_drv = 8'hC7;
        b_en = 1'b1; b_drv = 8'h3E;
        #1;
        check("t6_a_released", 32'(a), 32'h0000_00C7);
        check("t6_b_released", 32'(b), 32'h0000_003E);
        a_en = 1'b0; b_en = 1'b0;
        bus.oe_b_ = 1'b0;
        #1;
        check("t6_b_after_rst", 32'(b), 32'(drv('0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
